// File: rtl/car_sprite_loader.sv
// Streams pixels into the 32x32 car sprite RAM write port from a programmable base address.
// Optional horizontal mirroring of each 32-pixel row is enabled with CAR_SPRITE_LDR_HMIRROR_EN.
module car_sprite_loader #(
  parameter int CD   = 12,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [ADDR-1:0] base_addr,
  input  logic [ADDR:0]   len,
  input  logic            abort,
  input  logic            s_valid,
  input  logic [CD-1:0]   s_data,
`ifdef CAR_SPRITE_LDR_HMIRROR_EN
  input  logic            mirror,
`endif
  output logic            s_ready,
  output logic            we,
  output logic [ADDR-1:0] addr_w,
  output logic [CD-1:0]   pixel_in,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  localparam logic [ADDR:0] MAX_LEN = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] ONE     = {{ADDR{1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [ADDR-1:0] base_q, base_d;
  logic [ADDR:0]   eff_len_q, eff_len_d;
  logic [ADDR:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [CD-1:0]   pixel_q, pixel_d;
  logic [ADDR-1:0] a;
`ifdef CAR_SPRITE_LDR_HMIRROR_EN
  logic            mirror_q, mirror_d;
`endif

  // Address wraps naturally at 2**ADDR because the sum is truncated to ADDR bits.
  assign a = base_q + cnt_q[ADDR-1:0];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    base_d    = base_q;
    eff_len_d = eff_len_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    pixel_d   = pixel_q;
`ifdef CAR_SPRITE_LDR_HMIRROR_EN
    mirror_d  = mirror_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr;
          eff_len_d = (len > MAX_LEN) ? MAX_LEN : len;
          cnt_d     = '0;
`ifdef CAR_SPRITE_LDR_HMIRROR_EN
          mirror_d  = mirror;
`endif
          state_d   = (len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (s_valid) begin
          we_d    = 1'b1;
          pixel_d = s_data;
`ifdef CAR_SPRITE_LDR_HMIRROR_EN
          addr_d  = mirror_q ? {a[ADDR-1:5], ~a[4:0]} : a;
`else
          addr_d  = a;
`endif
          cnt_d   = cnt_q + ONE;
          if (cnt_q == eff_len_q - ONE) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      eff_len_q <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      pixel_q   <= '0;
`ifdef CAR_SPRITE_LDR_HMIRROR_EN
      mirror_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      eff_len_q <= eff_len_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      pixel_q   <= pixel_d;
`ifdef CAR_SPRITE_LDR_HMIRROR_EN
      mirror_q  <= mirror_d;
`endif
    end
  end

  assign s_ready  = (state_q == LOAD) && !abort;
  assign we       = we_q;
  assign addr_w   = addr_q;
  assign pixel_in = pixel_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule
